// File: rtl/norm2_pkg.sv
// norm2_pkg: widths, H column slices and driver
// state encoding shared by the norm2 datapath.
package norm2_pkg;

  localparam int W    = 16;
  localparam int FRAC = 11;

  localparam int COL0_MSB = 8*W-1;
  localparam int COL0_LSB = 4*W;
  localparam int COL1_MSB = 4*W-1;
  localparam int COL1_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND0,
    ST_SEND1,
    ST_COLLECT,
    ST_OUT
  } n2_state_t;

endpackage

// File: rtl/norm2_col_driver.sv
// norm2_col_driver: sends both H columns to norm2,
// gathers the two squared norms, hands them to ZF.
module norm2_col_driver
  import norm2_pkg::*;
#(
  parameter int W       = norm2_pkg::W,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [8*W-1:0] h_in,
  input  logic           h_valid,
  output logic           h_ready,
  output logic [4*W-1:0] n2_vector,
  output logic           n2_enable,
  input  logic           n2_accept_out,
  input  logic           n2_ready_out,
  input  logic [W-1:0]   n2_res,
  output logic           n2_accept_in,
  output logic [W-1:0]   nrm0,
  output logic [W-1:0]   nrm1,
  output logic [1:0]     zero_col,
  output logic           nrm_valid,
  input  logic           nrm_ready,
  output logic           timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  n2_state_t state_q;
  n2_state_t state_d;

  logic [4*W-1:0] col1_q;
  logic [4*W-1:0] vec_q;
  logic [1:0]     sent_q;
  logic [1:0]     recv_q;
  logic [TW-1:0]  timer_q;
  logic [W-1:0]   nrm0_q;
  logic [W-1:0]   nrm1_q;
  logic           tmo_q;

  logic h_xfer;
  logic v_xfer;
  logic r_xfer;
  logic tmo_hit;
  logic both_in;

  assign h_xfer       = h_valid & h_ready;
  assign v_xfer       = n2_enable & n2_accept_out;
  assign n2_accept_in = (recv_q < sent_q);
  assign r_xfer       = n2_ready_out & n2_accept_in;
  assign both_in      = (recv_q == 2'd2);
  assign tmo_hit      = (state_q == ST_COLLECT) & ~both_in
                      & (timer_q == TW'(TIMEOUT - 1));

  assign n2_vector   = vec_q;
  assign nrm0        = nrm0_q;
  assign nrm1        = nrm1_q;
  assign timeout_err = tmo_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    h_ready   = 1'b0;
    n2_enable = 1'b0;
    nrm_valid = 1'b0;
    zero_col  = 2'b00;
    unique case (state_q)
      ST_IDLE: begin
        h_ready = 1'b1;
        if (h_valid) state_d = ST_SEND0;
      end
      ST_SEND0: begin
        n2_enable = 1'b1;
        if (n2_accept_out) state_d = ST_SEND1;
      end
      ST_SEND1: begin
        n2_enable = 1'b1;
        if (n2_accept_out) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (both_in)      state_d = ST_OUT;
        else if (tmo_hit) state_d = ST_IDLE;
      end
      ST_OUT: begin
        nrm_valid = 1'b1;
        zero_col  = {nrm1_q == '0, nrm0_q == '0};
        if (nrm_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Column staging toward norm2
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col1_q <= '0;
      vec_q  <= '0;
    end else if (h_xfer) begin
      col1_q <= h_in[COL1_MSB:COL1_LSB];
      vec_q  <= h_in[COL0_MSB:COL0_LSB];
    end else if (v_xfer && state_q == ST_SEND0) begin
      vec_q  <= col1_q;
    end
  end

  // Sent/received bookkeeping and result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sent_q <= '0;
      recv_q <= '0;
      nrm0_q <= '0;
      nrm1_q <= '0;
    end else if (tmo_hit) begin
      sent_q <= '0;
      recv_q <= '0;
    end else if (h_xfer) begin
      sent_q <= '0;
      recv_q <= '0;
    end else begin
      if (v_xfer) sent_q <= sent_q + 2'd1;
      if (r_xfer) begin
        recv_q <= recv_q + 2'd1;
        if (recv_q == 2'd0) nrm0_q <= n2_res;
        else                nrm1_q <= n2_res;
      end
    end
  end

  // Collect watchdog and its error pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= tmo_hit;
      if (state_q == ST_SEND1 && v_xfer)
        timer_q <= '0;
      else if (state_q == ST_COLLECT)
        timer_q <= timer_q + TW'(1);
    end
  end

endmodule

// File: tb/tb_norm2_col_driver.sv
// tb_norm2_col_driver: norm2 stub with latency and
// stalls, column-norm reference, scenario tasks.
module tb_norm2_col_driver;
  import norm2_pkg::*;

  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [8*W-1:0] h_in;
  logic           h_valid;
  logic           h_ready;
  logic [4*W-1:0] n2_vector;
  logic           n2_enable;
  logic           n2_accept_out;
  logic           n2_ready_out;
  logic [W-1:0]   n2_res;
  logic           n2_accept_in;
  logic [W-1:0]   nrm0;
  logic [W-1:0]   nrm1;
  logic [1:0]     zero_col;
  logic           nrm_valid;
  logic           nrm_ready;
  logic           timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  norm2_col_driver #(.W(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .h_in(h_in), .h_valid(h_valid), .h_ready(h_ready),
    .n2_vector(n2_vector), .n2_enable(n2_enable),
    .n2_accept_out(n2_accept_out),
    .n2_ready_out(n2_ready_out), .n2_res(n2_res),
    .n2_accept_in(n2_accept_in),
    .nrm0(nrm0), .nrm1(nrm1), .zero_col(zero_col),
    .nrm_valid(nrm_valid), .nrm_ready(nrm_ready),
    .timeout_err(timeout_err)
  );

  // Behavioural norm2: sum of squares, rescaled by FRAC
  function automatic logic [W-1:0] norm_of(input logic [4*W-1:0] c);
    longint s;
    longint x;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      x = longint'($signed(c[W*i +: W]));
      s += x * x;
    end
    return W'(s >>> FRAC);
  endfunction

  typedef struct {
    logic [W-1:0] v;
    int           due;
  } res_t;

  res_t           rq[$];
  logic [4*W-1:0] vec_log[$];
  int             cyc = 0;
  int             stub_lat = 1;
  bit             stub_drop = 0;
  bit             stub_clear = 0;
  int             stall_left[2];
  int             vec_idx = 0;
  bit             vx_p = 0;
  bit             rx_p = 0;
  logic [4*W-1:0] vx_v;

  // norm2 stub: commits transfers at posedge, drives at negedge
  initial begin
    n2_accept_out = 1'b1;
    n2_ready_out  = 1'b0;
    n2_res        = '0;
    stall_left[0] = 0;
    stall_left[1] = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (stub_clear) begin
        rq.delete();
        vec_idx       = 0;
        stall_left[0] = 0;
        stall_left[1] = 0;
        stub_clear    = 0;
        vx_p          = 0;
        rx_p          = 0;
      end
      if (reset_n && vx_p) begin
        vec_log.push_back(vx_v);
        if (!(stub_drop && vec_idx == 1))
          rq.push_back('{v: norm_of(vx_v), due: cyc + stub_lat - 1});
        vec_idx = (vec_idx + 1) % 2;
      end
      if (reset_n && rx_p) void'(rq.pop_front());
      vx_p = 0;
      rx_p = 0;
      @(negedge clk);
      n2_accept_out = 1'b1;
      if (n2_enable && stall_left[vec_idx] > 0) begin
        n2_accept_out = 1'b0;
        stall_left[vec_idx]--;
      end
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        n2_ready_out = 1'b1;
        n2_res       = rq[0].v;
      end else begin
        n2_ready_out = 1'b0;
        n2_res       = W'($urandom);
      end
      #1;
      vx_p = n2_enable && n2_accept_out;
      vx_v = n2_vector;
      rx_p = n2_ready_out && n2_accept_in;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic stub_reset();
    stub_clear = 1;
    stub_drop  = 0;
    stub_lat   = 1;
    tick();
  endtask

  task automatic put_h(input logic [8*W-1:0] h);
    h_in    = h;
    h_valid = 1'b1;
    tick();
    h_valid = 1'b0;
    h_in    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_nrm(output int lat);
    lat = 1;
    while (!nrm_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  function automatic logic [8*W-1:0] rand_h();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({h_ready, n2_enable, n2_accept_in, nrm_valid,
         timeout_err, zero_col} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 1000000",
               {h_ready, n2_enable, n2_accept_in, nrm_valid,
                timeout_err, zero_col});
    end
    n_tests++;
    if ({n2_vector, nrm0, nrm1} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %h want 0",
               {n2_vector, nrm0, nrm1});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [8*W-1:0] h;
    logic [4*W-1:0] c0;
    logic [4*W-1:0] c1;
    int lat;
    h  = {64'h08A3070A08510666, 64'h070A066607D7075C};
    c0 = h[8*W-1:4*W];
    c1 = h[4*W-1:0];
    stub_reset();
    nrm_ready = 1'b1;
    vec_log.delete();
    put_h(h);
    wait_nrm(lat);
    n_tests++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL basic_latency got %0d want 5", lat);
    end
    n_tests++;
    if (nrm0 !== norm_of(c0) || nrm1 !== norm_of(c1)) begin
      n_fail++;
      $display("FAIL basic_norms got %h/%h want %h/%h",
               nrm0, nrm1, norm_of(c0), norm_of(c1));
    end
    n_tests++;
    if (zero_col !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_zero got %b want 00", zero_col);
    end
    n_tests++;
    if (vec_log.size() != 2 || vec_log[0] !== c0 || vec_log[1] !== c1) begin
      n_fail++;
      $display("FAIL basic_order got %0d vectors want 2 in order",
               vec_log.size());
    end
    tick();
    n_tests++;
    if ({nrm_valid, h_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_drop got %b want 01", {nrm_valid, h_ready});
    end
  endtask

  task automatic test_stall();
    logic [8*W-1:0] h;
    logic [4*W-1:0] c0;
    logic [4*W-1:0] c1;
    int n;
    int stalls;
    int bad;
    h  = {64'h08A3070A08510666, 64'h070A066607D7075C};
    c0 = h[8*W-1:4*W];
    c1 = h[4*W-1:0];
    stub_reset();
    stall_left[0] = 3;
    stall_left[1] = 2;
    vec_log.delete();
    put_h(h);
    n = 0;
    stalls = 0;
    bad = 0;
    while (!nrm_valid && n < 200) begin
      if (n2_enable) begin
        if (!n2_accept_out) stalls++;
        if (n2_vector !== (vec_log.size() == 0 ? c0 : c1)) bad++;
      end
      tick();
      n++;
    end
    n_tests++;
    if (stalls !== 5) begin
      n_fail++;
      $display("FAIL stall_count got %0d want 5", stalls);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL stall_vector_stable got %0d bad want 0", bad);
    end
    n_tests++;
    if (vec_log.size() != 2 || vec_log[0] !== c0 || vec_log[1] !== c1) begin
      n_fail++;
      $display("FAIL stall_order got %0d vectors want 2 in order",
               vec_log.size());
    end
    n_tests++;
    if (nrm0 !== norm_of(c0) || nrm1 !== norm_of(c1)) begin
      n_fail++;
      $display("FAIL stall_norms got %h/%h want %h/%h",
               nrm0, nrm1, norm_of(c0), norm_of(c1));
    end
    tick();
  endtask

  task automatic test_zero_col();
    logic [8*W-1:0] h;
    logic [1:0]     want;
    int lat;
    for (int k = 0; k < 2; k++) begin
      stub_reset();
      h = (k == 0) ? {64'h08A3070A08510666, 64'h0}
                   : {64'h0, 64'h070A066607D7075C};
      want = (k == 0) ? 2'b10 : 2'b01;
      put_h(h);
      wait_nrm(lat);
      n_tests++;
      if (zero_col !== want || nrm_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_col_%0d got %b want %b", k, zero_col, want);
      end
      n_tests++;
      if ((k == 0 && nrm1 !== 16'h0000) || (k == 1 && nrm0 !== 16'h0000)) begin
        n_fail++;
        $display("FAIL zero_norm_%0d got %h/%h want a zero norm",
                 k, nrm0, nrm1);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    logic [8*W-1:0] h;
    logic [8*W-1:0] h2;
    logic [W-1:0]   e0;
    logic [W-1:0]   e1;
    int lat;
    int bad;
    h  = rand_h();
    h2 = rand_h();
    e0 = norm_of(h[8*W-1:4*W]);
    e1 = norm_of(h[4*W-1:0]);
    stub_reset();
    nrm_ready = 1'b0;
    put_h(h);
    wait_nrm(lat);
    h_in    = h2;
    h_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (nrm_valid !== 1'b1 || h_ready !== 1'b0 || nrm0 !== e0 ||
          nrm1 !== e1 || zero_col !== {e1 == '0, e0 == '0}) bad++;
      tick();
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hold_stable got %0d bad cycles want 0", bad);
    end
    vec_log.delete();
    nrm_ready = 1'b1;
    tick();
    n_tests++;
    if ({nrm_valid, h_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL hold_release got %b want 01", {nrm_valid, h_ready});
    end
    tick();
    h_valid = 1'b0;
    wait_nrm(lat);
    n_tests++;
    if (lat !== 5 || nrm0 !== norm_of(h2[8*W-1:4*W]) ||
        nrm1 !== norm_of(h2[4*W-1:0])) begin
      n_fail++;
      $display("FAIL hold_second got lat %0d %h/%h want lat 5 %h/%h",
               lat, nrm0, nrm1, norm_of(h2[8*W-1:4*W]),
               norm_of(h2[4*W-1:0]));
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    int pulses;
    int saw_valid;
    stub_reset();
    stub_drop = 1;
    vec_log.delete();
    put_h(rand_h());
    n = 0;
    while (vec_log.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    n = 0;
    saw_valid = 0;
    while (!timeout_err && n < 200) begin
      if (nrm_valid) saw_valid++;
      tick();
      n++;
    end
    n_tests++;
    if (n !== TMO) begin
      n_fail++;
      $display("FAIL timeout_delay got %0d want %0d", n, TMO);
    end
    n_tests++;
    if (h_ready !== 1'b1 || n2_accept_in !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle got h_ready %b accept_in %b want 1 0",
               h_ready, n2_accept_in);
    end
    pulses = timeout_err ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (timeout_err) pulses++;
      if (nrm_valid) saw_valid++;
    end
    n_tests++;
    if (pulses !== 1 || saw_valid !== 0) begin
      n_fail++;
      $display("FAIL timeout_pulse got %0d pulses %0d valid want 1 0",
               pulses, saw_valid);
    end
    stub_reset();
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    int bad;
    stub_reset();
    stub_lat = 6;
    stall_left[1] = 4;
    vec_log.delete();
    put_h(rand_h());
    n = 0;
    while (vec_log.size() < 1 && n < 50) begin
      tick();
      n++;
    end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({h_ready, n2_enable, n2_accept_in, nrm_valid,
         timeout_err, zero_col} !== 7'b1000000 ||
        {n2_vector, nrm0, nrm1} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got %b %h want 1000000 0",
               {h_ready, n2_enable, n2_accept_in, nrm_valid,
                timeout_err, zero_col}, {n2_vector, nrm0, nrm1});
    end
    tick();
    reset_n = 1'b1;
    seen = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (n2_ready_out) seen++;
      if (n2_accept_in !== 1'b0 || n2_enable !== 1'b0) bad++;
    end
    n_tests++;
    if (seen == 0 || bad !== 0) begin
      n_fail++;
      $display("FAIL late_result got seen %0d bad %0d want >0 0",
               seen, bad);
    end
    stub_reset();
  endtask

  task automatic test_random();
    logic [8*W-1:0] h;
    logic [4*W-1:0] c0;
    logic [4*W-1:0] c1;
    logic [W-1:0]   e0;
    logic [W-1:0]   e1;
    int lat;
    int d;
    for (int it = 0; it < 16; it++) begin
      h = rand_h();
      if ($urandom_range(3) == 0) h[8*W-1:4*W] = '0;
      if ($urandom_range(3) == 0) h[4*W-1:0] = '0;
      c0 = h[8*W-1:4*W];
      c1 = h[4*W-1:0];
      e0 = norm_of(c0);
      e1 = norm_of(c1);
      stub_reset();
      stub_lat      = $urandom_range(4, 1);
      stall_left[0] = $urandom_range(3);
      stall_left[1] = $urandom_range(3);
      d = $urandom_range(3);
      nrm_ready = (d == 0);
      vec_log.delete();
      put_h(h);
      wait_nrm(lat);
      n_tests++;
      if ({nrm_valid, nrm0, nrm1, zero_col} !==
          {1'b1, e0, e1, e1 == '0, e0 == '0}) begin
        n_fail++;
        $display("FAIL rand_%0d_out got %b %h %h %b want %h %h",
                 it, nrm_valid, nrm0, nrm1, zero_col, e0, e1);
      end
      n_tests++;
      if (vec_log.size() != 2 || vec_log[0] !== c0 || vec_log[1] !== c1) begin
        n_fail++;
        $display("FAIL rand_%0d_order got %0d vectors want 2 in order",
                 it, vec_log.size());
      end
      repeat (d) tick();
      nrm_ready = 1'b1;
      tick();
      n_tests++;
      if (nrm_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_%0d_drop got %b want 0", it, nrm_valid);
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    h_in      = '0;
    h_valid   = 1'b0;
    nrm_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_zero_col();
    test_hold();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
